// File: rtl/cnnfreq_pkg.sv
// Shared types and defaults for the frequency-domain CNN datapath.
package cnnfreq_pkg;

  localparam int unsigned DEF_PARAKRN = 64;
  localparam int unsigned DEF_PARATIL = 9;
  localparam int unsigned DEF_DATALEN = 16;
  localparam int unsigned DEF_INDXLEN = 6;
  localparam int unsigned DEF_DEPTH   = 2;

  // Complex word, {imag, real}
  typedef logic [2*DEF_DATALEN-1:0] cplx_t;

  // One tile group as carried between multiplier array and accumulator
  typedef struct packed {
    cplx_t [DEF_PARATIL-1:0][DEF_PARAKRN-1:0] data;
    logic  [DEF_PARAKRN-1:0][DEF_INDXLEN-1:0] index;
    logic  [DEF_PARAKRN-1:0]                  lane;
  } group_t;

  // Occupancy of one main+skid register pair
  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } stage_state_e;

endpackage

// File: rtl/skid_stage.sv
// One elastic stage: main register plus skid register with registered
// upstream ready, so no combinational ready path crosses the stage.
module skid_stage
  import cnnfreq_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  stage_state_e r_state;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         w_accept;
  logic         w_take;

  assign w_accept  = in_valid & r_in_ready;
  assign w_take    = r_out_valid & out_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;

  // Stage FSM; flush clears valids only and leaves data registers untouched
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_main      <= in_data;
            r_state     <= BUSY;
            r_out_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (w_accept && w_take) begin
            r_main <= in_data;
          end else if (w_accept) begin
            r_skid     <= in_data;
            r_state    <= FULL;
            r_in_ready <= 1'b0;
          end else if (w_take) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (w_take) begin
            r_main     <= r_skid;
            r_state    <= BUSY;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/reg_slice_elastic.sv
// Elastic register slice for one tile group: lane masking at capture,
// DEPTH chained skid stages, and a held-group occupancy counter.
module reg_slice_elastic
  import cnnfreq_pkg::*;
#(
  parameter int unsigned PARAKRN = DEF_PARAKRN,
  parameter int unsigned PARATIL = DEF_PARATIL,
  parameter int unsigned DATALEN = DEF_DATALEN,
  parameter int unsigned INDXLEN = DEF_INDXLEN,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned CNTW    = $clog2(2*DEPTH+1)
) (
  input  logic                                       clk,
  input  logic                                       rstn,
  input  logic                                       flush,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [PARATIL-1:0][PARAKRN-1:0][2*DATALEN-1:0] indata,
  input  logic [PARAKRN-1:0][INDXLEN-1:0]            inindex,
  input  logic [PARAKRN-1:0]                         inlane,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [PARATIL-1:0][PARAKRN-1:0][2*DATALEN-1:0] outdata,
  output logic [PARAKRN-1:0][INDXLEN-1:0]            outindex,
  output logic [PARAKRN-1:0]                         outlane,
  output logic [CNTW-1:0]                            occupancy
);

  typedef struct packed {
    logic [PARATIL-1:0][PARAKRN-1:0][2*DATALEN-1:0] data;
    logic [PARAKRN-1:0][INDXLEN-1:0]                index;
    logic [PARAKRN-1:0]                             lane;
  } payload_t;

  localparam int unsigned W = $bits(payload_t);

  payload_t        w_in_pl;
  payload_t        w_out_pl;
  logic            w_valid [DEPTH+1];
  logic            w_ready [DEPTH+1];
  logic [W-1:0]    w_data  [DEPTH+1];
  logic            w_accept;
  logic            w_take;
  logic [CNTW-1:0] r_occ;

  // Zero data and index of inactive lanes before capture
  always_comb begin
    w_in_pl = '0;
    for (int unsigned k = 0; k < PARAKRN; k++) begin
      w_in_pl.lane[k] = inlane[k];
      if (inlane[k]) begin
        w_in_pl.index[k] = inindex[k];
        for (int unsigned t = 0; t < PARATIL; t++) begin
          w_in_pl.data[t][k] = indata[t][k];
        end
      end
    end
  end

  assign w_valid[0]     = in_valid;
  assign w_data[0]      = w_in_pl;
  assign in_ready       = w_ready[0];
  assign w_ready[DEPTH] = out_ready;
  assign out_valid      = w_valid[DEPTH];
  assign w_out_pl       = w_data[DEPTH];
  assign outdata        = w_out_pl.data;
  assign outindex       = w_out_pl.index;
  assign outlane        = w_out_pl.lane;

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_stage
    skid_stage #(
      .W(W)
    ) u_stage (
      .clk      (clk),
      .rstn     (rstn),
      .flush    (flush),
      .in_valid (w_valid[gi]),
      .in_ready (w_ready[gi]),
      .in_data  (w_data[gi]),
      .out_valid(w_valid[gi+1]),
      .out_ready(w_ready[gi+1]),
      .out_data (w_data[gi+1])
    );
  end

  assign w_accept  = in_valid & w_ready[0];
  assign w_take    = w_valid[DEPTH] & out_ready;
  assign occupancy = r_occ;

  // Held-group count: +accept -take, cleared by flush
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + CNTW'(w_accept) - CNTW'(w_take);
    end
  end

endmodule

// File: tb/tb_reg_slice_elastic.sv
// Directed bench for reg_slice_elastic with a seed-based scoreboard.
module tb_reg_slice_elastic;

  localparam int unsigned PK    = 64;
  localparam int unsigned PT    = 9;
  localparam int unsigned DL    = 16;
  localparam int unsigned IL    = 6;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNTW  = $clog2(2*DEPTH+1);

  typedef struct {
    int          seed;
    logic [63:0] lane;
  } sb_t;

  logic clk = 1'b0;
  logic rstn, flush, in_valid, out_ready;
  logic in_ready, out_valid;
  logic [PT-1:0][PK-1:0][2*DL-1:0] indata, outdata, ed;
  logic [PK-1:0][IL-1:0]           inindex, outindex, ei;
  logic [PK-1:0]                   inlane, outlane;
  logic [CNTW-1:0]                 occupancy;

  int   n_vec  = 0;
  int   n_fail = 0;
  int   cur_seed;
  logic [63:0] cur_lane;
  sb_t  sb[$];

  always #5 clk = ~clk;

  reg_slice_elastic #(
    .PARAKRN(PK), .PARATIL(PT), .DATALEN(DL), .INDXLEN(IL), .DEPTH(DEPTH), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .indata(indata), .inindex(inindex), .inlane(inlane),
    .out_valid(out_valid), .out_ready(out_ready),
    .outdata(outdata), .outindex(outindex), .outlane(outlane),
    .occupancy(occupancy)
  );

  function automatic logic [31:0] wgen(int s, int t, int k);
    return 32'(s) * 32'h9E3779B1 + 32'(t) * 32'h01000193 + 32'(k) * 32'h00010001;
  endfunction

  function automatic logic [5:0] igen(int s, int k);
    return 6'(s * 3 + k + 1);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_group(int s, logic [63:0] lane);
    for (int t = 0; t < PT; t++)
      for (int k = 0; k < PK; k++)
        indata[t][k] = wgen(s, t, k);
    for (int k = 0; k < PK; k++) inindex[k] = igen(s, k);
    inlane   = lane;
    cur_seed = s;
    cur_lane = lane;
  endtask

  task automatic chk_group(string tag, sb_t e);
    int bt, bk;
    bt = -1; bk = -1;
    for (int t = 0; t < PT; t++)
      for (int k = 0; k < PK; k++)
        ed[t][k] = e.lane[k] ? wgen(e.seed, t, k) : 32'h0;
    for (int k = 0; k < PK; k++) ei[k] = e.lane[k] ? igen(e.seed, k) : 6'h0;
    n_vec++;
    assert (outdata === ed) else begin
      n_fail++;
      for (int t = 0; t < PT; t++)
        for (int k = 0; k < PK; k++)
          if (bt < 0 && outdata[t][k] !== ed[t][k]) begin bt = t; bk = k; end
      $error("FAIL %s_data seed %0d word[%0d][%0d]: got %h expected %h",
             tag, e.seed, bt, bk, outdata[bt][bk], ed[bt][bk]);
    end
    chk({tag, "_index"}, outindex[63:0] ^ ei[63:0], 64'h0);
    chk({tag, "_lane"}, outlane, e.lane);
  endtask

  // One clock: score the take/accept seen before the edge, then check occupancy
  task automatic tick(output bit acc);
    bit tk;
    acc = in_valid && in_ready;
    tk  = out_valid && out_ready;
    if (tk) begin
      chk("take_expected", 64'(sb.size() != 0), 64'h1);
      if (sb.size() != 0) begin
        chk_group("out", sb[0]);
        void'(sb.pop_front());
      end
    end
    if (flush) sb.delete();
    else if (acc) sb.push_back('{seed: cur_seed, lane: cur_lane});
    @(posedge clk);
    #1;
    chk("occ", 64'(occupancy), 64'(sb.size()));
    @(negedge clk);
  endtask

  initial begin
    bit a;
    int nacc, seed, cyc;
    bit offering;

    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive_group(0, '0);
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_occ", 64'(occupancy), 64'h0);
    chk("rst_outdata_any", 64'(|outdata), 64'h0);
    chk("rst_outindex_any", 64'(|outindex), 64'h0);
    chk("rst_outlane", outlane, 64'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Streaming: 10 back-to-back groups, out_ready held high
    out_ready = 1'b1;
    for (int g = 0; g < 10; g++) begin
      drive_group(g + 1, '1);
      in_valid = 1'b1;
      chk("stream_in_ready", 64'(in_ready), 64'h1);
      tick(a);
      if (g == 0) chk("latency_cycle1_valid", 64'(out_valid), 64'h0);
      else begin
        chk("stream_out_valid", 64'(out_valid), 64'h1);
        chk("stream_occ2", 64'(occupancy), 64'h2);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick(a);
    chk("stream_drained", 64'(sb.size()), 64'h0);
    chk("stream_idle_valid", 64'(out_valid), 64'h0);

    // Backpressure: exactly 4 groups absorbed, then release
    out_ready = 1'b0;
    seed = 100;
    drive_group(seed, '1);
    in_valid = 1'b1;
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      chk("bp_in_ready", 64'(in_ready), (i < 4) ? 64'h1 : 64'h0);
      tick(a);
      if (a) begin nacc++; seed++; drive_group(seed, '1); end
    end
    chk("bp_accepted", 64'(nacc), 64'd4);
    chk("bp_occ4", 64'(occupancy), 64'h4);
    out_ready = 1'b1;
    chk("bp_release_valid", 64'(out_valid), 64'h1);
    for (int i = 0; i < 8; i++) begin
      tick(a);
      if (a) begin seed++; drive_group(seed, '1); end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 12 && sb.size() != 0; i++) tick(a);
    chk("bp_drained", 64'(sb.size()), 64'h0);

    // Lane mask: only lanes 0 and 2 active, lane 1 carries a marker
    drive_group(200, 64'h5);
    for (int t = 0; t < PT; t++) indata[t][1] = 32'h1234_5678;
    inindex[1] = 6'd7;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick(a);
    in_valid = 1'b0;
    tick(a);
    chk("mask_out_valid", 64'(out_valid), 64'h1);
    chk("mask_lane1_data", 64'(outdata[0][1]), 64'h0);
    chk("mask_lane1_index", 64'(outindex[1]), 64'h0);
    chk("mask_outlane", outlane, 64'h5);
    chk("mask_lane0_data", 64'(outdata[0][0]), 64'(wgen(200, 0, 0)));
    chk("mask_lane2_index", 64'(outindex[2]), 64'(igen(200, 2)));
    out_ready = 1'b1;
    tick(a);

    // Flush with a group offered on the same cycle
    out_ready = 1'b0;
    for (int g = 0; g < 3; g++) begin
      drive_group(300 + g, '1);
      in_valid = 1'b1;
      tick(a);
    end
    chk("flush_pre_occ3", 64'(occupancy), 64'h3);
    drive_group(399, '1);
    flush = 1'b1;
    chk("flush_in_ready", 64'(in_ready), 64'h1);
    tick(a);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'h0);
    chk("flush_in_ready_after", 64'(in_ready), 64'h1);
    chk("flush_occ", 64'(occupancy), 64'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(a);
      chk("flush_no_ghost", 64'(out_valid), 64'h0);
    end

    // Asynchronous reset with three groups held
    out_ready = 1'b0;
    for (int g = 0; g < 3; g++) begin
      drive_group(400 + g, '1);
      in_valid = 1'b1;
      tick(a);
    end
    in_valid = 1'b0;
    chk("areset_pre_occ3", 64'(occupancy), 64'h3);
    #2 rstn = 1'b0;
    #1;
    chk("areset_out_valid", 64'(out_valid), 64'h0);
    chk("areset_in_ready", 64'(in_ready), 64'h1);
    chk("areset_occ", 64'(occupancy), 64'h0);
    chk("areset_outlane", outlane, 64'h0);
    chk("areset_outdata_any", 64'(|outdata), 64'h0);
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;
    chk("areset_release_ready", 64'(in_ready), 64'h1);
    for (int i = 0; i < 5; i++) begin
      tick(a);
      chk("areset_no_stale", 64'(out_valid), 64'h0);
    end

    // Random valid/ready on both sides, 10k groups
    nacc = 0; cyc = 0; offering = 1'b0;
    while (nacc < 10000 && cyc < 60000) begin
      if (!offering && $urandom_range(0, 1) == 1) begin
        drive_group(1000 + nacc, {$urandom, $urandom});
        offering = 1'b1;
      end
      in_valid  = offering;
      out_ready = ($urandom_range(0, 1) == 1);
      tick(a);
      if (a) begin offering = 1'b0; nacc++; end
      cyc++;
    end
    chk("rand_accepted", 64'(nacc), 64'd10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick(a);
    chk("rand_drained", 64'(sb.size()), 64'h0);
    chk("rand_final_occ", 64'(occupancy), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_slice_elastic.md
# reg_slice_elastic

Parametrised elastic register slice carrying one tile group of complex frequency-domain products between the multiplier array and the sparse accumulator. Each group holds PARATIL×PARAKRN complex words, plus a per-kernel index and a per-kernel lane-valid. The block inserts DEPTH skid-buffered stages with full valid/ready backpressure, zero-fills inactive lanes, supports a synchronous flush, and reports occupancy. It is the successor to the plain free-running register stage and is used wherever timing closure needs registers that must also honour downstream stalls.

## Interface
- PARAKRN, 64, kernel lanes per group
- PARATIL, 9, tile positions per lane
- DATALEN, 16, bits per real/imag half; complex word is 2*DATALEN ({imag, real})
- INDXLEN, 6, kernel index width
- DEPTH, 2, number of skid stages (≥1); capacity 2*DEPTH groups
- CNTW, $clog2(2*DEPTH+1), occupancy counter width
- clk  in  1  single clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous discard of all held groups
- in_valid  in  1  upstream group valid
- in_ready  out  1  slice can accept this cycle
- indata  in  [PARATIL][PARAKRN]×2*DATALEN  complex products
- inindex  in  [PARAKRN]×INDXLEN  kernel index per lane
- inlane  in  [PARAKRN]×1  lane-valid per lane
- out_valid  out  1  group available
- out_ready  in  1  downstream takes group
- outdata, outindex, outlane  out  same shapes as inputs
- occupancy  out  CNTW  groups currently held

## Operation
- Accept = in_valid & in_ready; take = out_valid & out_ready.
- Lane masking at capture: for any lane k with inlane[k]=0, all PARATIL data words and inindex[k] are stored as 0. outlane mirrors inlane.
- Each stage has a main register and a skid register. States:
  - EMPTY: main invalid. Accept → BUSY.
  - BUSY: main valid, skid empty.
    - Accept & take → BUSY (main replaced).
    - Accept & !take → FULL (new group into skid).
    - !accept & take → EMPTY.
  - FULL: main and skid valid. Take → BUSY (main←skid).
- Stage upstream ready = !skid_valid, registered, so there is no combinational ready path through the slice. Stage downstream valid = main_valid.
- Stages chain: stage i output feeds stage i+1 input. Stage 0 ready is in_ready; the last stage drives out_*.
- Order is strictly preserved; no group is duplicated or dropped except by flush.
- occupancy ← occupancy + accept − take, computed at full width; it never exceeds 2*DEPTH.
- Flush has priority over every other event:
  - all main/skid valids clear;
  - occupancy ← 0;
  - a group offered on the flush cycle is discarded even though in_ready is high.
  - Data registers keep their contents; only valids clear.
- Reset mid-operation: all held groups are lost and there is no partial-group output.

## Timing
- Reset values:
  - out_valid 0, in_ready 1, occupancy 0;
  - outdata, outindex, outlane all 0;
  - all internal valids 0.
- Latency: DEPTH cycles from accept to out_valid when never stalled.
- Throughput: one group per cycle with out_ready held high.
- Stall: after out_ready drops, in_ready drops no earlier than the cycle following the cycle on which stage-0 skid fills; at most 2*DEPTH groups are absorbed.
- Stall release: out_ready rising gives a take in the same cycle. in_ready reasserts one cycle after stage-0 skid empties.
- Simultaneous accept and take on a FULL slice is impossible at stage 0 (in_ready=0). Internal stages resolve it per the BUSY rules.
- Flush: on the cycle after flush, out_valid=0, in_ready=1, occupancy=0.

## Structure
- Shared package cnnfreq_pkg holds:
  - DATALEN, INDXLEN, PARAKRN, PARATIL defaults;
  - typedef cplx_t (2*DATALEN packed);
  - typedef group payload struct {data, index, lane};
  - the stage-state enum (EMPTY, BUSY, FULL).
- One sub-module, skid_stage, holds one main+skid pair for the packed payload. It is instantiated DEPTH times in a generate loop. Lane masking and the occupancy counter live in the top.

## Test plan
- Streaming: DEPTH=2, 10 groups on consecutive cycles, out_ready=1 → first out_valid at cycle 2 after the first accept; all 10 groups in order; occupancy steady at 2.
- Backpressure: out_ready=0 with continuous in_valid → exactly 4 groups accepted, then in_ready=0 and occupancy=4. Raising out_ready drains groups 1..4 in order before group 5.
- Lane mask: inlane=0x…0005 with lane 1 data 0x1234_5678 and index 7 → out lane 1 data 0 and index 0; lanes 0 and 2 unchanged.
- Flush with accept: 3 groups held, flush=1 with in_valid=1 → next cycle out_valid=0, occupancy=0, and the offered group never appears.
- Async reset mid-stream: drop rstn between clock edges with occupancy 3 → outputs go to reset values immediately; after release in_ready=1 and no stale group is emitted.
- Random valid/ready: 50% toggling on both sides over 10k groups → scoreboard matches, no loss or reorder, and occupancy always equals accepted minus taken.
